conv_host_responder: RTL and testbench

- Synthesizable host-side responder for the CONV accelerator interface; it is the memory/controller end of the CONV ready/busy, image-read, layer-write and layer-read ports.
- Holds the 4096x20 input image, the L0 (4096x20, csel=001) and L1 (1024x20, csel=011) result memories, and runs the start/ready/busy session.
- Exposes a dump port for post-run readback by an on-chip checker or scan logic.

---
 rtl/conv_host_responder.sv | 174 +++++++++++++++++
 tb/tb_conv_host_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_host_responder.sv
// rtl/conv_host_responder.sv - host-side image/layer memory responder for the CONV accelerator
// Runs the start/ready/busy session FSM and serves image reads, L0/L1 layer traffic and dump readback.
module conv_host_responder #(
  parameter int DATA_W   = 20,
  parameter int AW       = 12,
  parameter int L1_DEPTH = 1024,
  parameter int TIMEOUT  = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ready,
  input  logic              busy,
  input  logic [AW-1:0]     iaddr,
  output logic [DATA_W-1:0] idata,
  input  logic              cwr,
  input  logic [AW-1:0]     caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic              crd,
  input  logic [AW-1:0]     caddr_rd,
  output logic [DATA_W-1:0] cdata_rd,
  input  logic [2:0]        csel,
  input  logic              dump_en,
  input  logic              dump_sel,
  input  logic [AW-1:0]     dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic              timeout,
  output logic              check0,
  output logic              check1,
  output logic              sel_err,
  output logic [12:0]       wr_cnt0,
  output logic [10:0]       wr_cnt1
);

  localparam int L1_AW     = $clog2(L1_DEPTH);
  localparam int IMG_DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0] r_img [IMG_DEPTH];
  logic [DATA_W-1:0] r_l0  [IMG_DEPTH];
  logic [DATA_W-1:0] r_l1  [L1_DEPTH];

  logic [DATA_W-1:0] r_idata, r_cdata_rd, r_dump;
  logic [31:0]       r_tmo_cnt;
  logic              r_timeout, r_check0, r_check1, r_sel_err;
  logic [12:0]       r_wr_cnt0;
  logic [10:0]       r_wr_cnt1;

  logic w_ready, w_done, w_run, w_active, w_host_side;
  logic w_arm_entry, w_tmo_hit, w_ld;
  logic w_wr_l1_ok, w_rd_l1_ok;
  logic w_wr_en, w_rd_en, w_l0_wr, w_l1_wr, w_l0_rd, w_l1_rd, w_wr_err, w_rd_err;

  assign w_run       = (r_state == S_RUN);
  assign w_active    = (r_state == S_ARM) || (r_state == S_RUN);
  assign w_host_side = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_arm_entry = w_host_side && start;
  assign w_tmo_hit   = w_active && (r_tmo_cnt == 32'(TIMEOUT - 1));
  assign w_ld        = reset && ld_en && w_host_side;

  // L1 range check is done one bit wider so L1_DEPTH == 2**AW cannot wrap to zero
  assign w_wr_l1_ok = {1'b0, caddr_wr} < (AW + 1)'(L1_DEPTH);
  assign w_rd_l1_ok = {1'b0, caddr_rd} < (AW + 1)'(L1_DEPTH);
  assign w_wr_en    = reset && w_run && cwr;
  assign w_rd_en    = reset && w_run && crd;
  assign w_l0_wr    = w_wr_en && (csel == 3'b001);
  assign w_l1_wr    = w_wr_en && (csel == 3'b011) && w_wr_l1_ok;
  assign w_l0_rd    = w_rd_en && (csel == 3'b001);
  assign w_l1_rd    = w_rd_en && (csel == 3'b011) && w_rd_l1_ok;
  assign w_wr_err   = w_wr_en && !(w_l0_wr || w_l1_wr);
  assign w_rd_err   = w_rd_en && !(w_l0_rd || w_l1_rd);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_ARM;
      S_ARM: begin
        if (w_tmo_hit)  w_next = S_DONE;
        else if (busy)  w_next = S_RUN;
      end
      S_RUN: begin
        if (w_tmo_hit || !busy) w_next = S_DONE;
      end
      S_DONE: if (start) w_next = S_ARM;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_ARM:   w_ready = 1'b1;
      S_DONE:  w_done  = 1'b1;
      default: ;
    endcase
  end

  // Memories are never cleared; nonblocking writes give read-before-write on collisions
  always_ff @(posedge clk) begin
    if (w_ld)    r_img[ld_addr] <= ld_data;
    if (w_l0_wr) r_l0[caddr_wr] <= cdata_wr;
    if (w_l1_wr) r_l1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idata    <= '0;
      r_cdata_rd <= '0;
      r_dump     <= '0;
      r_tmo_cnt  <= '0;
      r_timeout  <= 1'b0;
      r_check0   <= 1'b0;
      r_check1   <= 1'b0;
      r_sel_err  <= 1'b0;
      r_wr_cnt0  <= '0;
      r_wr_cnt1  <= '0;
    end else begin
      r_idata <= w_run ? r_img[iaddr] : '0;
      if (w_l0_rd)      r_cdata_rd <= r_l0[caddr_rd];
      else if (w_l1_rd) r_cdata_rd <= r_l1[caddr_rd[L1_AW-1:0]];
      if (dump_en && w_host_side)
        r_dump <= dump_sel ? r_l1[dump_addr[L1_AW-1:0]] : r_l0[dump_addr];

      if (w_arm_entry)   r_tmo_cnt <= '0;
      else if (w_active) r_tmo_cnt <= r_tmo_cnt + 32'd1;

      if (w_arm_entry) begin
        r_timeout <= 1'b0;
        r_check0  <= 1'b0;
        r_check1  <= 1'b0;
        r_sel_err <= 1'b0;
        r_wr_cnt0 <= '0;
        r_wr_cnt1 <= '0;
      end else begin
        if (w_tmo_hit) r_timeout <= 1'b1;
        if (w_l0_wr) begin
          r_check0 <= 1'b1;
          if (r_wr_cnt0 != '1) r_wr_cnt0 <= r_wr_cnt0 + 13'd1;
        end
        if (w_l1_wr) begin
          r_check1 <= 1'b1;
          if (r_wr_cnt1 != '1) r_wr_cnt1 <= r_wr_cnt1 + 11'd1;
        end
        if (w_wr_err || w_rd_err) r_sel_err <= 1'b1;
      end
    end
  end

  assign ready     = w_ready;
  assign done      = w_done;
  assign idata     = r_idata;
  assign cdata_rd  = r_cdata_rd;
  assign dump_data = r_dump;
  assign timeout   = r_timeout;
  assign check0    = r_check0;
  assign check1    = r_check1;
  assign sel_err   = r_sel_err;
  assign wr_cnt0   = r_wr_cnt0;
  assign wr_cnt1   = r_wr_cnt1;

endmodule

// File: tb/tb_conv_host_responder.sv
// tb/tb_conv_host_responder.sv - directed self-checking bench for conv_host_responder
module tb_conv_host_responder;

  logic        clk = 1'b0;
  logic        reset, start, start2, ld_en, busy, cwr, crd, dump_en, dump_sel;
  logic [11:0] ld_addr, iaddr, caddr_wr, caddr_rd, dump_addr;
  logic [19:0] ld_data, cdata_wr;
  logic [2:0]  csel;

  logic        ready, done, timeout, check0, check1, sel_err;
  logic [19:0] idata, cdata_rd, dump_data;
  logic [12:0] wr_cnt0;
  logic [10:0] wr_cnt1;

  logic        ready2, done2, timeout2, check0_2, check1_2, sel_err2;
  logic [19:0] idata2, cdata_rd2, dump_data2;
  logic [12:0] wr_cnt0_2;
  logic [10:0] wr_cnt1_2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_host_responder dut (
    .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .dump_en(dump_en), .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data),
    .done(done), .timeout(timeout), .check0(check0), .check1(check1), .sel_err(sel_err),
    .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1)
  );

  conv_host_responder #(.TIMEOUT(16)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .ready(ready2), .busy(1'b0), .iaddr(iaddr), .idata(idata2), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd2), .csel(csel),
    .dump_en(dump_en), .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data2),
    .done(done2), .timeout(timeout2), .check0(check0_2), .check1(check1_2), .sel_err(sel_err2),
    .wr_cnt0(wr_cnt0_2), .wr_cnt1(wr_cnt1_2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start2 = 1'b0; ld_en = 1'b0; busy = 1'b1;
    cwr = 1'b1; crd = 1'b1; csel = 3'b001; caddr_wr = 12'd7; caddr_rd = 12'd7;
    cdata_wr = 20'h00003; ld_addr = 12'd0; ld_data = 20'h0; iaddr = 12'd5;
    dump_en = 1'b1; dump_sel = 1'b0; dump_addr = 12'd7;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_check0", 32'(check0), 32'd0);
    chk("rst_check1", 32'(check1), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_wr_cnt0", 32'(wr_cnt0), 32'd0);
    chk("rst_wr_cnt1", 32'(wr_cnt1), 32'd0);
    chk("rst_idata", 32'(idata), 32'd0);
    chk("rst_cdata_rd", 32'(cdata_rd), 32'd0);
    chk("rst_dump_data", 32'(dump_data), 32'd0);

    reset = 1'b1; busy = 1'b0; cwr = 1'b0; crd = 1'b0; dump_en = 1'b0;
    ld_en = 1'b1; ld_addr = 12'd5; ld_data = 20'h0ABCD;
    tick();
    ld_en = 1'b0;
    tick();
    chk("idle_idata_zero", 32'(idata), 32'd0);
    chk("idle_ready", 32'(ready), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_ready", 32'(ready), 32'd1);
    repeat (2) tick();
    chk("arm_ready_hold", 32'(ready), 32'd1);
    busy = 1'b1;
    tick();
    chk("run_ready_drop", 32'(ready), 32'd0);
    tick();
    chk("run_idata", 32'(idata), 32'h0ABCD);

    cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd4095; cdata_wr = 20'hFFFFF;
    tick();
    csel = 3'b011; caddr_wr = 12'd1023; cdata_wr = 20'h00012;
    tick();
    cwr = 1'b0; crd = 1'b1; csel = 3'b001; caddr_rd = 12'd4095;
    tick();
    crd = 1'b0;
    chk("rd_l0_4095", 32'(cdata_rd), 32'hFFFFF);
    chk("wr_check0", 32'(check0), 32'd1);
    chk("wr_check1", 32'(check1), 32'd1);
    chk("wr_cnt0_one", 32'(wr_cnt0), 32'd1);
    chk("wr_cnt1_one", 32'(wr_cnt1), 32'd1);
    chk("no_err_yet", 32'(sel_err), 32'd0);

    cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd0; cdata_wr = 20'h00055;
    tick();
    csel = 3'b010; caddr_wr = 12'd4095; cdata_wr = 20'h00003;
    tick();
    chk("err_bad_csel", 32'(sel_err), 32'd1);
    csel = 3'b011; caddr_wr = 12'd1024; cdata_wr = 20'h00777;
    tick();
    cwr = 1'b0;
    chk("err_cnt0", 32'(wr_cnt0), 32'd1);
    chk("err_cnt1", 32'(wr_cnt1), 32'd2);
    crd = 1'b1; csel = 3'b000; caddr_rd = 12'd0;
    tick();
    crd = 1'b0;
    chk("rd_bad_csel_hold", 32'(cdata_rd), 32'hFFFFF);

    cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd7; cdata_wr = 20'h00001;
    tick();
    cdata_wr = 20'h00002; crd = 1'b1; caddr_rd = 12'd7;
    tick();
    cwr = 1'b0; crd = 1'b0;
    chk("rbw_old_data", 32'(cdata_rd), 32'h00001);
    chk("rbw_cnt0", 32'(wr_cnt0), 32'd3);
    crd = 1'b1;
    tick();
    crd = 1'b0;
    chk("rd_new_data", 32'(cdata_rd), 32'h00002);

    ld_en = 1'b1; ld_addr = 12'd5; ld_data = 20'h11111;
    tick();
    ld_en = 1'b0;
    tick();
    chk("ld_ignored_in_run", 32'(idata), 32'h0ABCD);

    busy = 1'b0;
    tick();
    chk("done_set", 32'(done), 32'd1);
    chk("done_no_timeout", 32'(timeout), 32'd0);
    tick();
    chk("done_idata_zero", 32'(idata), 32'd0);

    dump_en = 1'b1; dump_sel = 1'b1; dump_addr = 12'd1023;
    tick();
    chk("dump_l1_1023", 32'(dump_data), 32'h00012);
    dump_addr = 12'd0;
    tick();
    chk("dump_l1_0", 32'(dump_data), 32'h00055);
    dump_sel = 1'b0; dump_addr = 12'd4095;
    tick();
    chk("dump_l0_4095", 32'(dump_data), 32'hFFFFF);
    dump_addr = 12'd7;
    tick();
    chk("dump_l0_7", 32'(dump_data), 32'h00002);
    dump_en = 1'b0; dump_addr = 12'd4095;
    tick();
    chk("dump_hold", 32'(dump_data), 32'h00002);

    cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd7; cdata_wr = 20'h00009;
    tick();
    cwr = 1'b0; dump_en = 1'b1; dump_addr = 12'd7;
    tick();
    dump_en = 1'b0;
    chk("wr_outside_run_cnt", 32'(wr_cnt0), 32'd3);
    chk("wr_outside_run_mem", 32'(dump_data), 32'h00002);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rearm_done_clr", 32'(done), 32'd0);
    chk("rearm_ready", 32'(ready), 32'd1);
    chk("rearm_check0", 32'(check0), 32'd0);
    chk("rearm_check1", 32'(check1), 32'd0);
    chk("rearm_sel_err", 32'(sel_err), 32'd0);
    chk("rearm_cnt0", 32'(wr_cnt0), 32'd0);
    chk("rearm_cnt1", 32'(wr_cnt1), 32'd0);

    busy = 1'b1;
    tick();
    cwr = 1'b1; csel = 3'b001;
    for (int i = 0; i < 8200; i++) begin
      caddr_wr = 12'(i);
      cdata_wr = 20'(i);
      tick();
    end
    chk("sat_cnt0", 32'(wr_cnt0), 32'd8191);
    csel = 3'b011;
    for (int i = 0; i < 2050; i++) begin
      caddr_wr = 12'(i % 1024);
      tick();
    end
    cwr = 1'b0;
    chk("sat_cnt1", 32'(wr_cnt1), 32'd2047);
    chk("sat_cnt0_hold", 32'(wr_cnt0), 32'd8191);
    busy = 1'b0;
    tick();
    chk("done_second", 32'(done), 32'd1);

    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("tmo_ready", 32'(ready2), 32'd1);
    repeat (15) tick();
    chk("tmo_not_yet_done", 32'(done2), 32'd0);
    chk("tmo_not_yet_ready", 32'(ready2), 32'd1);
    tick();
    chk("tmo_done", 32'(done2), 32'd1);
    chk("tmo_flag", 32'(timeout2), 32'd1);
    chk("tmo_ready_drop", 32'(ready2), 32'd0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("tmo_flag_clr", 32'(timeout2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
